alu_sequencer: RTL and testbench
================================

# alu_sequencer

Upstream issue stage for the 3-bit ALU. Accepts packed instructions `{op, A, B}` over a valid/ready handshake and buffers them in a small FIFO. Drives the ALU's `ALU_OP`/`A`/`B` inputs one instruction at a time, waits a fixed settle interval, then captures the ALU's 6-bit `Dout` into a result register offered downstream over a second valid/ready handshake.

## Interface
- `DEPTH`, default 4: instruction FIFO entries; power of two, 2..16.
- `SETTLE`, default 1: clock edges between ALU inputs changing and result capture; range 1..15.

- `clk`  in  1: single clock; all state updates on rising edge.
- `rst_n`  in  1: reset; synchronous and active-low.
- `in_valid`  in  1: instruction offered.
- `in_ready`  out  1: FIFO can accept; `!full && rst_n`.
- `in_instr`  in  8: `[7:6]` op, `[5:3]` A, `[2:0]` B.
- `alu_op`  out  2: to `ALU_OP`.
- `alu_a`  out  3: to `A`.
- `alu_b`  out  3: to `B`.
- `alu_dout`  in  6: from ALU `Dout`; combinational, sampled only at capture.
- `res_valid`  out  1: result register holds an unconsumed result.
- `res_ready`  in  1: downstream accepts result.
- `res_data`  out  6: captured `alu_dout`, unmodified.
- `res_op`  out  2: op that produced `res_data`.
- `busy`  out  1: state != IDLE or FIFO non-empty.
- `fifo_count`  out  `$clog2(DEPTH)+1`: current FIFO occupancy.

## Operation
- Reset (`rst_n` low at an edge):
  - FIFO is emptied and pointers are zeroed.
  - State goes to IDLE and the settle counter is cleared.
  - `alu_op`/`alu_a`/`alu_b` become 0; `res_valid`, `res_data` and `res_op` become 0.
  - An in-flight instruction or held result is discarded. No partial state survives.
- Push: on an edge with `in_valid && in_ready`, write `in_instr` at the tail.
  - `in_ready` depends only on `full`. A push is refused when the FIFO is full, even if a pop occurs on the same edge.
- States:
  - **IDLE**, FIFO non-empty: pop the head into the `alu_*` registers, load the settle counter with `SETTLE-1`, go to DRIVE.
  - **DRIVE**:
    - If the counter is non-zero, decrement it.
    - If the counter is 0: `res_data <= alu_dout`, `res_op <= alu_op`, `res_valid <= 1`, go to HOLD.
  - **HOLD**: `res_valid` stays high and `res_data`/`res_op` stay stable until `res_ready`. On an edge with `res_ready`:
    - `res_valid <= 0`.
    - If the FIFO is non-empty, pop the next instruction into `alu_*`, reload the counter and go to DRIVE (no IDLE bubble).
    - Otherwise go to IDLE.
- `alu_*` registers hold their last value in IDLE and HOLD; they change only on a pop.
- Push and pop on the same edge are allowed (not full): the count is unchanged and the pointers wrap modulo DEPTH.
- No arithmetic is performed on the result. The ALU range (add 0..14, mul 0..49) fits in 6 bits and passes through unaltered.

## Timing
- Push at edge N, FIFO previously empty, state IDLE:
  - Pop at edge N+1, so `alu_*` change after N+1.
  - Capture at edge N+1+SETTLE, so `res_valid` is high in the cycle after that edge.
  - Minimum accept-to-result latency is 1+SETTLE edges (2 with the default).
- Back-to-back with `res_ready` tied high: one result every SETTLE+1 edges.
- `fifo_count` and `in_ready` reflect a push or pop from the edge at which it occurs.
- `in_ready` is 0 in any cycle where `rst_n` is low.
- `res_valid` never drops without a `res_ready` handshake, except on reset.

## Test plan
- Single add, `SETTLE`=1: push `8'b10_011_101` (3+5) at edge N. Required: `alu_op`=2, `alu_a`=3, `alu_b`=5 after N+1; `res_valid`=1 and `res_data`=8, `res_op`=2 after N+2.
- Back-to-back, `res_ready` high: push mul 7*7, add 7+7, mul 2*3 on consecutive edges. Required: results 49, 14, 6 in order, spaced 2 edges apart, `busy` low afterwards.
- Backpressure/full: `res_ready` low, push 6 instructions. Required:
  - The first instruction is popped and `res_valid` is held with a stable value.
  - 4 more instructions fill the FIFO (`fifo_count`=4, `in_ready`=0) and the 6th is refused.
  - After releasing `res_ready`, exactly 5 results arrive in order.
- `SETTLE`=3: push 4*5, with `alu_dout` modelled to change 2 edges after its inputs. Required: `res_data`=20, captured 3 edges after the pop, latency 4 edges.
- Reset mid-operation: deassert `rst_n` for one edge while in DRIVE with 2 entries queued. Required: next cycle has `res_valid`=0, `fifo_count`=0, `alu_*`=0, state IDLE; no stale result ever appears.
- Pointer wrap: 10 push/pop pairs with `DEPTH`=4, `res_ready` high. Required: all 10 results correct and in order.

Source files
------------

// File: rtl/alu_sequencer.sv
// Issue stage for the 3-bit ALU: buffers {op, A, B} instructions, drives the ALU one at a time,
// waits a fixed settle interval, then offers the captured Dout downstream.
module alu_sequencer #(
  parameter int unsigned Depth  = 4,
  parameter int unsigned Settle = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [7:0]              in_instr_i,
  output logic [1:0]              alu_op_o,
  output logic [2:0]              alu_a_o,
  output logic [2:0]              alu_b_o,
  input  logic [5:0]              alu_dout_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [5:0]              res_data_o,
  output logic [1:0]              res_op_o,
  output logic                    busy_o,
  output logic [$clog2(Depth):0]  fifo_count_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDrive = 2'd1;
  localparam logic [1:0] StHold  = 2'd2;

  localparam logic [3:0]     SettleLoad = 4'(Settle - 1);
  localparam logic [AddrW:0] DepthC     = (AddrW + 1)'(Depth);

  logic [7:0]       mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]   count_q, count_d;
  logic [1:0]       state_q, state_d;
  logic [3:0]       settle_q, settle_d;
  logic [1:0]       alu_op_q;
  logic [2:0]       alu_a_q, alu_b_q;
  logic             res_valid_q, res_valid_d;
  logic [5:0]       res_data_q;
  logic [1:0]       res_op_q;

  logic       full, empty, push, pop, capture;
  logic [7:0] head;

  assign full  = (count_q == DepthC);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Ready ignores a same-edge pop so a full FIFO never accepts.
  assign in_ready_o = !full && rst_ni;
  assign push       = in_valid_i && in_ready_o;

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    res_valid_d = res_valid_q;
    pop         = 1'b0;
    capture     = 1'b0;
    case (state_q)
      StIdle: begin
        if (!empty) begin
          pop      = 1'b1;
          settle_d = SettleLoad;
          state_d  = StDrive;
        end
      end
      StDrive: begin
        if (settle_q != 4'd0) begin
          settle_d = settle_q - 4'd1;
        end else begin
          capture     = 1'b1;
          res_valid_d = 1'b1;
          state_d     = StHold;
        end
      end
      StHold: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          if (!empty) begin
            pop      = 1'b1;
            settle_d = SettleLoad;
            state_d  = StDrive;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AddrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AddrW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AddrW + 1)'(1);
      2'b01:   count_d = count_q - (AddrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_instr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= StIdle;
      settle_q    <= 4'd0;
      alu_op_q    <= 2'd0;
      alu_a_q     <= 3'd0;
      alu_b_q     <= 3'd0;
      res_valid_q <= 1'b0;
      res_data_q  <= 6'd0;
      res_op_q    <= 2'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      settle_q    <= settle_d;
      res_valid_q <= res_valid_d;
      if (pop) begin
        alu_op_q <= head[7:6];
        alu_a_q  <= head[5:3];
        alu_b_q  <= head[2:0];
      end
      if (capture) begin
        res_data_q <= alu_dout_i;
        res_op_q   <= alu_op_q;
      end
    end
  end

  assign alu_op_o     = alu_op_q;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign res_valid_o  = res_valid_q;
  assign res_data_o   = res_data_q;
  assign res_op_o     = res_op_q;
  assign busy_o       = (state_q != StIdle) || !empty;
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench: two instances (settle 1 with a combinational ALU, settle 3 with an ALU whose
// output lags its inputs by two edges), expected results queued on accept and checked on handshake.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [5:0] alu_f(input logic [1:0] op, input logic [2:0] a,
                                       input logic [2:0] b);
    case (op)
      2'd0:    return {3'd0, a & b};
      2'd1:    return {3'd0, a | b};
      2'd2:    return 6'(a) + 6'(b);
      default: return 6'(a) * 6'(b);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance with SETTLE=1
  logic       in_valid, in_ready, res_valid, res_ready, busy;
  logic [7:0] in_instr;
  logic [1:0] alu_op, res_op;
  logic [2:0] alu_a, alu_b, fifo_count;
  logic [5:0] alu_dout, res_data;

  assign alu_dout = alu_f(alu_op, alu_a, alu_b);

  alu_sequencer #(.Depth(4), .Settle(1)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_instr_i   (in_instr),
    .alu_op_o     (alu_op),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_dout_i   (alu_dout),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_data_o   (res_data),
    .res_op_o     (res_op),
    .busy_o       (busy),
    .fifo_count_o (fifo_count)
  );

  // Instance with SETTLE=3
  logic       in_valid3, in_ready3, res_valid3, res_ready3, busy3;
  logic [7:0] in_instr3;
  logic [1:0] alu_op3, res_op3;
  logic [2:0] alu_a3, alu_b3, fifo_count3;
  logic [5:0] res_data3, lag1, lag2;

  always @(posedge clk) begin
    lag1 <= alu_f(alu_op3, alu_a3, alu_b3);
    lag2 <= lag1;
  end

  alu_sequencer #(.Depth(4), .Settle(3)) dut3 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid3),
    .in_ready_o   (in_ready3),
    .in_instr_i   (in_instr3),
    .alu_op_o     (alu_op3),
    .alu_a_o      (alu_a3),
    .alu_b_o      (alu_b3),
    .alu_dout_i   (lag2),
    .res_valid_o  (res_valid3),
    .res_ready_i  (res_ready3),
    .res_data_o   (res_data3),
    .res_op_o     (res_op3),
    .busy_o       (busy3),
    .fifo_count_o (fifo_count3)
  );

  // Scoreboards: sampled on the falling edge, describing the transfers of the next rising edge.
  logic [7:0] exp_q[$];
  logic [7:0] exp_q3[$];
  int         hs_cyc[$];
  int         hs_n = 0;
  int         hs_n3 = 0;
  logic       hold_v = 1'b0, hold_v3 = 1'b0;
  logic [7:0] hold_d, hold_d3;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) chk("s1_hold_stable", {res_valid, res_op, res_data}, {1'b1, hold_d});
      if (in_valid && in_ready)
        exp_q.push_back({in_instr[7:6], alu_f(in_instr[7:6], in_instr[5:3], in_instr[2:0])});
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL s1_unexpected_result: got op %0d data %0d, required none", res_op,
                   res_data);
        end else begin
          chk("s1_result", {res_op, res_data}, exp_q.pop_front());
        end
        hs_n++;
        hs_cyc.push_back(cyc);
      end
      hold_v = res_valid && !res_ready;
      hold_d = {res_op, res_data};
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q3.delete();
      hold_v3 = 1'b0;
    end else begin
      if (hold_v3) chk("s3_hold_stable", {res_valid3, res_op3, res_data3}, {1'b1, hold_d3});
      if (in_valid3 && in_ready3)
        exp_q3.push_back({in_instr3[7:6],
                          alu_f(in_instr3[7:6], in_instr3[5:3], in_instr3[2:0])});
      if (res_valid3 && res_ready3) begin
        if (exp_q3.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL s3_unexpected_result: got op %0d data %0d, required none", res_op3,
                   res_data3);
        end else begin
          chk("s3_result", {res_op3, res_data3}, exp_q3.pop_front());
        end
        hs_n3++;
      end
      hold_v3 = res_valid3 && !res_ready3;
      hold_d3 = {res_op3, res_data3};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int base;
    int g;
    rst_n = 1'b0;
    in_valid = 1'b0;  in_instr = '0;  res_ready = 1'b1;
    in_valid3 = 1'b0; in_instr3 = '0; res_ready3 = 1'b1;

    // Reset state
    repeat (2) tick();
    chk("reset_in_ready", in_ready, 0);
    chk("reset_alu", {alu_op, alu_a, alu_b}, 0);
    chk("reset_res", {res_valid, res_op, res_data}, 0);
    chk("reset_count", fifo_count, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", in_ready, 1);
    chk("idle_busy", busy, 0);

    // Single add 3+5, pushed at edge N
    res_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 8'b10_011_101;
    tick();
    in_valid = 1'b0;
    chk("add_count_push", fifo_count, 1);
    tick();
    chk("add_alu_inputs", {alu_op, alu_a, alu_b}, {2'd2, 3'd3, 3'd5});
    chk("add_not_yet_valid", res_valid, 0);
    chk("add_count_pop", fifo_count, 0);
    tick();
    chk("add_res_valid", res_valid, 1);
    chk("add_res_data", res_data, 8);
    chk("add_res_op", res_op, 2);
    res_ready = 1'b1;
    repeat (3) tick();
    chk("add_busy_after", busy, 0);

    // Back-to-back: 7*7, 7+7, 2*3
    hs_cyc.delete();
    in_valid = 1'b1;
    in_instr = 8'b11_111_111;
    tick();
    in_instr = 8'b10_111_111;
    tick();
    in_instr = 8'b11_010_011;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    chk("b2b_result_count", hs_cyc.size(), 3);
    if (hs_cyc.size() == 3) begin
      chk("b2b_spacing_1", hs_cyc[1] - hs_cyc[0], 2);
      chk("b2b_spacing_2", hs_cyc[2] - hs_cyc[1], 2);
    end
    chk("b2b_busy_after", busy, 0);

    // Backpressure: 6 offered with no consumer, 5 fit (1 in flight + 4 queued)
    res_ready = 1'b0;
    base = hs_n;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_instr = 8'($urandom);
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_accepted", acc, 5);
    chk("bp_count_full", fifo_count, 4);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_res_valid_held", res_valid, 1);
    repeat (3) tick();
    chk("bp_count_still_full", fifo_count, 4);
    res_ready = 1'b1;
    repeat (20) tick();
    chk("bp_results_drained", hs_n - base, 5);
    chk("bp_busy_after", busy, 0);

    // SETTLE=3 with lagging ALU: 4*5
    in_valid3 = 1'b1;
    in_instr3 = 8'b11_100_101;
    tick();
    in_valid3 = 1'b0;
    tick();
    chk("s3_alu_inputs", {alu_op3, alu_a3, alu_b3}, {2'd3, 3'd4, 3'd5});
    repeat (2) tick();
    chk("s3_not_early", res_valid3, 0);
    tick();
    chk("s3_res_valid", res_valid3, 1);
    chk("s3_res_data", res_data3, 20);
    repeat (4) tick();
    chk("s3_busy_after", busy3, 0);

    // Reset while in DRIVE with two entries queued
    in_valid3 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_instr3 = 8'($urandom);
      tick();
    end
    in_valid3 = 1'b0;
    chk("rst_pre_count", fifo_count3, 2);
    chk("rst_pre_busy", busy3, 1);
    rst_n = 1'b0;
    tick();
    chk("rst_in_ready_low", in_ready3, 0);
    rst_n = 1'b1;
    chk("rst_res_valid", res_valid3, 0);
    chk("rst_count", fifo_count3, 0);
    chk("rst_alu", {alu_op3, alu_a3, alu_b3}, 0);
    chk("rst_res", {res_op3, res_data3}, 0);
    chk("rst_idle", busy3, 0);
    repeat (12) tick();
    chk("rst_no_stale_valid", res_valid3, 0);
    chk("rst_still_idle", busy3, 0);

    // Pointer wrap: 10 accepted instructions, consumer always ready
    base = hs_n;
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_instr = 8'($urandom);
      g = 0;
      while (!in_ready && g < 50) begin
        tick();
        g++;
      end
      if (g >= 50) begin
        n_cmp++;
        n_err++;
        $display("FAIL wrap_ready_timeout: in_ready stuck at %0d, required 1", in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    repeat (30) tick();
    chk("wrap_results", hs_n - base, 10);

    // Random traffic on both instances
    for (int i = 0; i < 300; i++) begin
      in_valid   = 1'($urandom);
      in_instr   = 8'($urandom);
      res_ready  = ($urandom_range(0, 3) != 0);
      in_valid3  = 1'($urandom);
      in_instr3  = 8'($urandom);
      res_ready3 = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    in_valid3 = 1'b0;
    res_ready = 1'b1;
    res_ready3 = 1'b1;
    repeat (60) tick();
    chk("final_s1_queue_empty", exp_q.size(), 0);
    chk("final_s3_queue_empty", exp_q3.size(), 0);
    chk("final_s1_busy", busy, 0);
    chk("final_s3_busy", busy3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
